// File: rtl/bus_pkg.sv
// Shared definitions for system-bus masters: slave select encodings,
// address-region codes, controller state type and the region decoder.
package bus_pkg;

   localparam logic [2:0] SEL_NONE = 3'b000;
   localparam logic [2:0] SEL_S1   = 3'b001;
   localparam logic [2:0] SEL_S2   = 3'b010;
   localparam logic [2:0] SEL_S3   = 3'b011;

   localparam logic [1:0] REGION_S1       = 2'b00;
   localparam logic [1:0] REGION_S2       = 2'b01;
   localparam logic [1:0] REGION_S3       = 2'b10;
   localparam logic [1:0] REGION_UNMAPPED = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_WAIT,
      ST_DONE
   } bus_mst_state_t;

   typedef struct packed {
      logic [2:0] sel;
      logic       unmapped;
   } region_dec_t;

   // Map the two region bits of an address onto a slave select.
   function automatic region_dec_t region_to_select(input logic [1:0] region);
      region_dec_t dec;
      dec.sel      = SEL_NONE;
      dec.unmapped = 1'b0;
      case (region)
         REGION_S1: dec.sel = SEL_S1;
         REGION_S2: dec.sel = SEL_S2;
         REGION_S3: dec.sel = SEL_S3;
         default:   dec.unmapped = 1'b1;
      endcase
      return dec;
   endfunction

endpackage

// File: rtl/bus_master_ctrl_if.sv
// Client request/response and system-bus signals of one bus master.
// The master modport is the controller's view; slave is the environment's.
interface bus_master_ctrl_if #(
   parameter int ADDR_W = 14,
   parameter int DATA_W = 8
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              resp_valid;
   logic              resp_ready;
   logic [DATA_W-1:0] resp_rdata;
   logic              resp_err;
   logic [2:0]        bus_select;
   logic              bus_valid;
   logic              bus_we;
   logic [ADDR_W-3:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic [DATA_W-1:0] bus_rdata;
   logic              bus_ready;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata, resp_ready, bus_rdata, bus_ready,
      output req_ready, resp_valid, resp_rdata, resp_err,
             bus_select, bus_valid, bus_we, bus_addr, bus_wdata
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata, resp_ready, bus_rdata, bus_ready,
      input  req_ready, resp_valid, resp_rdata, resp_err,
             bus_select, bus_valid, bus_we, bus_addr, bus_wdata
   );
endinterface

// File: rtl/bus_addr_decode.sv
// Combinational address-region decoder, shareable between bus masters.
module bus_addr_decode
   import bus_pkg::*;
(
   input  logic [1:0] region,
   output logic [2:0] sel,
   output logic       unmapped
);
   region_dec_t dec;

   assign dec      = region_to_select(region);
   assign sel      = dec.sel;
   assign unmapped = dec.unmapped;
endmodule

// File: rtl/bus_master_ctrl.sv
// Master-side transaction controller: accepts one client request at a time,
// runs it on the system bus (select, strobes, registered ready) and returns
// read data with an error flag. All outputs come straight from flops.
module bus_master_ctrl
   import bus_pkg::*;
#(
   parameter int ADDR_W         = 14,
   parameter int DATA_W         = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   bus_master_ctrl_if.master    bif
);
   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
   localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);

   bus_mst_state_t    state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              req_ready_q, req_ready_d;
   logic              resp_valid_q, resp_valid_d;
   logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
   logic              resp_err_q, resp_err_d;
   logic [2:0]        bus_select_q, bus_select_d;
   logic              bus_valid_q, bus_valid_d;
   logic              bus_we_q, bus_we_d;
   logic [ADDR_W-3:0] bus_addr_q, bus_addr_d;
   logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;

   logic [2:0]        dec_sel;
   logic              dec_unmapped;

   bus_addr_decode u_decode (
      .region   (bif.req_addr[ADDR_W-1 -: 2]),
      .sel      (dec_sel),
      .unmapped (dec_unmapped)
   );

   // Next-state and next-output logic; bus_ready is only looked at in WAIT,
   // since the ready mux delivers it one cycle late and it is stale elsewhere.
   always_comb begin
      state_d      = state_q;
      cnt_d        = '0;
      req_ready_d  = 1'b0;
      resp_valid_d = resp_valid_q;
      resp_rdata_d = resp_rdata_q;
      resp_err_d   = resp_err_q;
      bus_select_d = bus_select_q;
      bus_valid_d  = bus_valid_q;
      bus_we_d     = bus_we_q;
      bus_addr_d   = bus_addr_q;
      bus_wdata_d  = bus_wdata_q;

      case (state_q)
         ST_IDLE: begin
            req_ready_d = 1'b1;
            if (bif.req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               if (dec_unmapped) begin
                  state_d      = ST_DONE;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
                  resp_rdata_d = '0;
               end else begin
                  state_d      = ST_SETTLE;
                  bus_select_d = dec_sel;
                  bus_valid_d  = 1'b1;
                  bus_we_d     = bif.req_we;
                  bus_addr_d   = bif.req_addr[ADDR_W-3:0];
                  bus_wdata_d  = bif.req_wdata;
               end
            end
         end
         ST_SETTLE: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            if (bif.bus_ready) begin
               state_d      = ST_DONE;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b0;
               resp_rdata_d = bus_we_q ? '0 : bif.bus_rdata;
               bus_select_d = SEL_NONE;
               bus_valid_d  = 1'b0;
               bus_we_d     = 1'b0;
               bus_addr_d   = '0;
               bus_wdata_d  = '0;
            end else if (TMO_EN && (cnt_q == CNT_LAST)) begin
               state_d      = ST_DONE;
               resp_valid_d = 1'b1;
               resp_err_d   = 1'b1;
               resp_rdata_d = '0;
               bus_select_d = SEL_NONE;
               bus_valid_d  = 1'b0;
               bus_we_d     = 1'b0;
               bus_addr_d   = '0;
               bus_wdata_d  = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            if (bif.resp_ready) begin
               state_d      = ST_IDLE;
               resp_valid_d = 1'b0;
               req_ready_d  = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         req_ready_q  <= 1'b0;
         resp_valid_q <= 1'b0;
         resp_rdata_q <= '0;
         resp_err_q   <= 1'b0;
         bus_select_q <= SEL_NONE;
         bus_valid_q  <= 1'b0;
         bus_we_q     <= 1'b0;
         bus_addr_q   <= '0;
         bus_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_ready_q  <= req_ready_d;
         resp_valid_q <= resp_valid_d;
         resp_rdata_q <= resp_rdata_d;
         resp_err_q   <= resp_err_d;
         bus_select_q <= bus_select_d;
         bus_valid_q  <= bus_valid_d;
         bus_we_q     <= bus_we_d;
         bus_addr_q   <= bus_addr_d;
         bus_wdata_q  <= bus_wdata_d;
      end
   end

   assign bif.req_ready  = req_ready_q;
   assign bif.resp_valid = resp_valid_q;
   assign bif.resp_rdata = resp_rdata_q;
   assign bif.resp_err   = resp_err_q;
   assign bif.bus_select = bus_select_q;
   assign bif.bus_valid  = bus_valid_q;
   assign bif.bus_we     = bus_we_q;
   assign bif.bus_addr   = bus_addr_q;
   assign bif.bus_wdata  = bus_wdata_q;

endmodule

// File: tb/tb_bus_master_ctrl.sv
// Bench for bus_master_ctrl: each transaction is planned up front as a
// timeline (bus window, response window, handshake) and the expected
// outputs of every cycle are written into a table that a compare process
// checks against the DUT at each falling edge.
module tb_bus_master_ctrl;
   localparam int ADDR_W = 14;
   localparam int DATA_W = 8;
   localparam int TMO    = 16;
   localparam int TBL    = 4096;

   typedef struct packed {
      logic        chk;
      logic        req_ready;
      logic        resp_valid;
      logic [7:0]  rdata;
      logic        err;
      logic [2:0]  sel;
      logic        bvalid;
      logic        bwe;
      logic [11:0] baddr;
      logic [7:0]  bwdata;
   } obs_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_errors = 0;
   obs_t exp_tbl [TBL];
   obs_t act_tbl [TBL];

   bus_master_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

   bus_master_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TMO)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bif   (bif)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic obs_t idle_e();
      obs_t e;
      e = '0;
      e.chk = 1'b1;
      e.req_ready = 1'b1;
      return e;
   endfunction

   function automatic obs_t reset_e();
      obs_t e;
      e = '0;
      e.chk = 1'b1;
      return e;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
      end
   endtask

   // Per-cycle compare of every DUT output against the planned timeline.
   initial begin
      obs_t s, e;
      forever begin
         @(negedge clk);
         if (cyc < TBL) begin
            s.chk        = 1'b1;
            s.req_ready  = bif.req_ready;
            s.resp_valid = bif.resp_valid;
            s.rdata      = bif.resp_rdata;
            s.err        = bif.resp_err;
            s.sel        = bif.bus_select;
            s.bvalid     = bif.bus_valid;
            s.bwe        = bif.bus_we;
            s.baddr      = bif.bus_addr;
            s.bwdata     = bif.bus_wdata;
            act_tbl[cyc] = s;
            e = exp_tbl[cyc];
            if (e.chk) begin
               check("req_ready", 32'(s.req_ready), 32'(e.req_ready));
               check("resp_valid", 32'(s.resp_valid), 32'(e.resp_valid));
               if (e.resp_valid) begin
                  check("resp_rdata", 32'(s.rdata), 32'(e.rdata));
                  check("resp_err", 32'(s.err), 32'(e.err));
               end
               check("bus_select", 32'(s.sel), 32'(e.sel));
               check("bus_valid", 32'(s.bvalid), 32'(e.bvalid));
               check("bus_we", 32'(s.bwe), 32'(e.bwe));
               check("bus_addr", 32'(s.baddr), 32'(e.baddr));
               check("bus_wdata", 32'(s.bwdata), 32'(e.bwdata));
            end
         end
      end
   end

   // One transaction, started on a falling edge where the controller is idle.
   // n: index of the WAIT cycle that sees ready (>= TMO means never).
   // r: DONE cycles of backpressure before resp_ready. rst_k: WAIT index at
   // which reset is applied (-1 for none). Returns on an idle falling edge.
   task automatic do_txn(input bit we, input logic [13:0] addr, input logic [7:0] wd,
                         input logic [7:0] rd, input int n, input int r,
                         input bit x_settle, input int rst_k,
                         output int a_o, output int d_o);
      int a, d, nw, last, k;
      bit mapped, tmo;
      logic [2:0] sel;
      logic [7:0] exp_rd;
      obs_t e;
      a      = cyc + 1;
      mapped = (addr[13:12] != 2'b11);
      sel    = mapped ? (3'(addr[13:12]) + 3'd1) : 3'd0;
      tmo    = mapped && (n >= TMO);
      nw     = !mapped ? 0 : (tmo ? TMO : n + 1);
      d      = mapped ? (a + 1 + nw) : a;
      exp_rd = (mapped && !tmo && !we) ? rd : 8'h00;
      last   = d + r + 1;
      a_o    = a;
      d_o    = d;
      for (int i = a; i <= last && i < TBL; i++) begin
         e = reset_e();
         e.req_ready = (i == last);
         if (i < d) begin
            e.sel    = sel;
            e.bvalid = 1'b1;
            e.bwe    = we;
            e.baddr  = addr[11:0];
            e.bwdata = wd;
         end else if (i < last) begin
            e.resp_valid = 1'b1;
            e.rdata      = exp_rd;
            e.err        = !mapped || tmo;
         end
         exp_tbl[i] = e;
      end
      bif.req_valid  = 1'b1;
      bif.req_we     = we;
      bif.req_addr   = addr;
      bif.req_wdata  = wd;
      bif.resp_ready = 1'b0;
      bif.bus_ready  = 1'($urandom);
      bif.bus_rdata  = 8'($urandom);
      @(negedge clk);
      for (int c = a; c < last; c++) begin
         bif.req_valid = 1'($urandom);
         bif.req_we    = 1'($urandom);
         bif.req_addr  = 14'($urandom);
         bif.req_wdata = 8'($urandom);
         bif.bus_rdata = 8'($urandom);
         if (c < d) begin
            bif.resp_ready = 1'($urandom);
            if (c == a) begin
               bif.bus_ready = x_settle ? 1'bx : 1'($urandom);
            end else begin
               k = c - a - 1;
               bif.bus_ready = (k == n);
               if (k == n) bif.bus_rdata = rd;
               if (k == rst_k) begin
                  rst_n = 1'b0;
                  if (c + 1 < TBL) exp_tbl[c+1] = reset_e();
                  for (int i = c + 2; i <= last && i < TBL; i++) exp_tbl[i] = idle_e();
                  @(negedge clk);
                  rst_n          = 1'b1;
                  bif.req_valid  = 1'b0;
                  bif.bus_ready  = 1'b0;
                  bif.resp_ready = 1'b0;
                  @(negedge clk);
                  d_o = c + 1;
                  return;
               end
            end
         end else begin
            bif.bus_ready  = ($urandom % 3 == 0) ? 1'bx : 1'b1;
            bif.resp_ready = (c == d + r);
         end
         @(negedge clk);
      end
      bif.req_valid  = 1'b0;
      bif.bus_ready  = 1'b0;
      bif.resp_ready = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         bif.req_valid  = 1'b0;
         bif.req_addr   = 14'($urandom);
         bif.bus_ready  = ($urandom % 2 == 0) ? 1'bx : 1'b1;
         bif.resp_ready = 1'($urandom);
         @(negedge clk);
      end
      bif.bus_ready  = 1'b0;
      bif.resp_ready = 1'b0;
   endtask

   initial begin
      int a, d, a2, d2, n, r, rk, p;
      bit we;
      logic [13:0] addr;
      for (int i = 0; i < TBL; i++) exp_tbl[i] = idle_e();
      exp_tbl[0].chk = 1'b0;
      exp_tbl[1] = reset_e();
      exp_tbl[2] = reset_e();
      rst_n = 1'b0;
      bif.req_valid = 1'b0; bif.req_we = 1'b0; bif.req_addr = '0; bif.req_wdata = '0;
      bif.resp_ready = 1'b0; bif.bus_rdata = '0; bif.bus_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_req_ready", 32'(act_tbl[1].req_ready), 0);
      check("rst_resp_valid", 32'(act_tbl[1].resp_valid), 0);
      check("rst_rdata", 32'(act_tbl[2].rdata), 0);
      check("rst_err", 32'(act_tbl[2].err), 0);
      check("rst_sel", 32'(act_tbl[2].sel), 0);
      check("rst_bvalid", 32'(act_tbl[2].bvalid), 0);

      // Read of s2, ready on the first WAIT cycle.
      do_txn(1'b0, 14'h1005, 8'h00, 8'hA5, 0, 0, 1'b0, -1, a, d);
      check("rd_sel_settle", 32'(act_tbl[a].sel), 32'h2);
      check("rd_addr", 32'(act_tbl[a].baddr), 32'h005);
      check("rd_sel_wait", 32'(act_tbl[a+1].sel), 32'h2);
      check("rd_no_early_resp", 32'(act_tbl[a+1].resp_valid), 0);
      check("rd_resp_valid", 32'(act_tbl[a+2].resp_valid), 1);
      check("rd_rdata", 32'(act_tbl[a+2].rdata), 32'hA5);
      check("rd_sel_done", 32'(act_tbl[a+2].sel), 0);

      // Write of s1, ready after 4 idle WAIT cycles.
      do_txn(1'b1, 14'h0010, 8'h3C, 8'h77, 4, 0, 1'b0, -1, a, d);
      check("wr_we", 32'(act_tbl[a+5].bwe), 1);
      check("wr_wdata", 32'(act_tbl[a+5].bwdata), 32'h3C);
      check("wr_sel", 32'(act_tbl[a+5].sel), 32'h1);
      check("wr_resp_valid", 32'(act_tbl[a+6].resp_valid), 1);
      check("wr_rdata", 32'(act_tbl[a+6].rdata), 0);
      check("wr_sel_after", 32'(act_tbl[a+6].sel), 0);

      // Unmapped region.
      do_txn(1'b0, 14'h3000, 8'h00, 8'h11, 0, 1, 1'b0, -1, a, d);
      check("um_resp_valid", 32'(act_tbl[a].resp_valid), 1);
      check("um_err", 32'(act_tbl[a].err), 1);
      check("um_rdata", 32'(act_tbl[a].rdata), 0);
      check("um_bvalid", 32'(act_tbl[a].bvalid), 0);

      // Timeout on s3, late ready in DONE.
      do_txn(1'b0, 14'h2001, 8'h00, 8'h5A, 99, 2, 1'b0, -1, a, d);
      check("to_last_wait_valid", 32'(act_tbl[a+16].bvalid), 1);
      check("to_last_wait_resp", 32'(act_tbl[a+16].resp_valid), 0);
      check("to_resp_valid", 32'(act_tbl[a+17].resp_valid), 1);
      check("to_err", 32'(act_tbl[a+17].err), 1);
      check("to_rdata", 32'(act_tbl[a+17].rdata), 0);

      // Ready on the final WAIT cycle beats the timeout.
      do_txn(1'b0, 14'h2002, 8'h00, 8'hC3, 15, 0, 1'b0, -1, a, d);
      check("edge_resp_valid", 32'(act_tbl[a+17].resp_valid), 1);
      check("edge_err", 32'(act_tbl[a+17].err), 0);
      check("edge_rdata", 32'(act_tbl[a+17].rdata), 32'hC3);

      // Backpressure with X on ready in SETTLE.
      do_txn(1'b0, 14'h1ABC, 8'h00, 8'h96, 1, 5, 1'b1, -1, a, d);
      check("bp_hold_valid", 32'(act_tbl[a+8].resp_valid), 1);
      check("bp_hold_rdata", 32'(act_tbl[a+8].rdata), 32'h96);
      check("bp_req_ready", 32'(act_tbl[a+8].req_ready), 0);

      // Back-to-back requests.
      do_txn(1'b1, 14'h0123, 8'h5E, 8'h00, 0, 0, 1'b0, -1, a, d);
      do_txn(1'b0, 14'h0456, 8'h00, 8'h3D, 2, 0, 1'b0, -1, a2, d2);
      check("b2b_gap_sel", 32'(act_tbl[d].sel), 0);
      check("b2b_second_sel", 32'(act_tbl[a2].sel), 32'h1);

      // Reset in the middle of WAIT, then a clean read of s3.
      do_txn(1'b0, 14'h2010, 8'h00, 8'h00, 99, 0, 1'b0, 3, a, d);
      check("mid_rst_bvalid", 32'(act_tbl[d].bvalid), 0);
      check("mid_rst_sel", 32'(act_tbl[d].sel), 0);
      check("mid_rst_resp", 32'(act_tbl[d].resp_valid), 0);
      check("mid_rst_rdata", 32'(act_tbl[d].rdata), 0);
      do_txn(1'b0, 14'h2345, 8'h00, 8'h4B, 1, 0, 1'b0, -1, a, d);
      check("post_rst_rdata", 32'(act_tbl[a+3].rdata), 32'h4B);

      // Randomized traffic.
      for (int t = 0; t < 80; t++) begin
         we   = 1'($urandom);
         addr = 14'($urandom);
         p    = $urandom % 10;
         if (p < 6)      n = $urandom % 5;
         else if (p < 8) n = 5 + ($urandom % 11);
         else            n = TMO + ($urandom % 3);
         r  = $urandom % 4;
         rk = -1;
         if ($urandom % 12 == 0)
            rk = $urandom % (((n < TMO) ? n : TMO - 1) + 1);
         do_txn(we, addr, 8'($urandom), 8'($urandom), n, r, 1'($urandom), rk, a, d);
         idle($urandom % 3);
      end
      idle(2);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d got=running want=finished", cyc);
      $fatal(1, "watchdog");
   end
endmodule
